// File: rtl/imem_responder.sv
// Instruction-memory responder for the Fetch stage.
// Boots from a valid/ready loader port, then serves one fetch at a time with
// a fixed read latency. Holds the PC via stall_req while a read is pending
// and drops the pending read on a redirect (flush).
`timescale 1ns/1ps

module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        boot_done,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        addr_fault,
    output logic        stall_req
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {LOAD, IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     addr_q;
    logic [31:0]     rd_q;
    logic            fault_q;
    logic [31:0]     instr_hold_q;
    logic [31:0]     addr_hold_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            ld_fire;
    logic            load_done;
    logic            accept;
    logic            launch_new;
    logic            launch_old;
    logic [31:0]     rd_addr;
    logic            rd_fault;
    logic [AW-1:0]   rd_idx;

    // Misaligned, or word index beyond the array.
    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    assign ld_fire   = ld_ready && ld_valid;
    assign load_done = ld_fire && (ld_last || (wptr_q == AW'(DEPTH_WORDS - 1)));

    // New requests are taken when idle, in the response cycle, or alongside a flush.
    assign accept = req_valid &&
                    ((state_q == IDLE) ||
                     ((state_q == BUSY) && (flush || (cnt_q == '0))));

    // The array is read on the edge that enters the response cycle, so the word
    // is already registered while rsp_valid is high.
    assign launch_new = accept && (LATENCY == 1);
    assign launch_old = (state_q == BUSY) && !flush && (cnt_q == CW'(1));
    assign rd_addr    = launch_new ? req_addr : addr_q;
    assign rd_fault   = is_fault(rd_addr);
    assign rd_idx     = rd_addr[AW+1:2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_done) state_d = IDLE;
            IDLE:    if (req_valid) state_d = BUSY;
            BUSY:    if (flush || (cnt_q == '0)) state_d = req_valid ? BUSY : IDLE;
            default: state_d = LOAD;
        endcase
    end

    // FSM outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        ld_ready  = 1'b0;
        rsp_valid = 1'b0;
        stall_req = 1'b0;
        case (state_q)
            LOAD: begin
                ld_ready  = 1'b1;
                stall_req = 1'b1;
            end
            BUSY: begin
                rsp_valid = (cnt_q == '0) && !flush;
                stall_req = !rsp_valid;
            end
            default: ;
        endcase
    end

    // Instruction array: loader writes and fetch reads.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive rst_n by design.
        if (ld_fire) mem[wptr_q] <= ld_data;
        if ((launch_new || launch_old) && !rd_fault) rd_q <= mem[rd_idx];
    end

    // Load pointer, latency counter, request address and response hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            fault_q      <= 1'b0;
            instr_hold_q <= NOP_INSTR;
            addr_hold_q  <= '0;
        end else begin
            if (ld_fire) wptr_q <= wptr_q + 1'b1;

            if (accept)
                cnt_q <= CW'(LATENCY - 1);
            else if (state_q == BUSY) begin
                if (flush)              cnt_q <= '0;
                else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
            end

            if (accept) addr_q <= req_addr;
            if (launch_new || launch_old) fault_q <= rd_fault;

            if (rsp_valid) begin
                instr_hold_q <= fault_q ? NOP_INSTR : rd_q;
                addr_hold_q  <= addr_q;
            end
        end
    end

    assign boot_done  = (state_q != LOAD);
    assign rsp_instr  = rsp_valid ? (fault_q ? NOP_INSTR : rd_q) : instr_hold_q;
    assign rsp_addr   = rsp_valid ? addr_q : addr_hold_q;
    assign addr_fault = rsp_valid && fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH_WORDS=1024, LATENCY=2).
`timescale 1ns/1ps

module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        boot_done;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        addr_fault;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    imem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (2),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .boot_done (boot_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .addr_fault(addr_fault),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge of the current cycle for sampling.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic check_idle_out(input string tag, input logic [31:0] held_instr, input logic [31:0] held_addr);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_fault"}, {31'd0, addr_fault}, 32'd0);
        check({tag, "_instr"}, rsp_instr, held_instr);
        check({tag, "_addr"},  rsp_addr,  held_addr);
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [31:0] addr, input logic fault);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_instr"}, rsp_instr, instr);
        check({tag, "_addr"},  rsp_addr,  addr);
        check({tag, "_fault"}, {31'd0, addr_fault}, {31'd0, fault});
        check({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    endtask

    // Single read with no interference: request, wait, response, back to idle.
    task automatic read_one(input string tag, input logic [31:0] a, input logic [31:0] instr, input logic fault);
        req_valid = 1'b1; req_addr = a;
        step();
        req_valid = 1'b0;
        mid();
        check({tag, "_wait_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_wait_stall"}, {31'd0, stall_req}, 32'd1);
        step();
        mid();
        check_rsp(tag, instr, a, fault);
        step();
    endtask

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        req_valid = 1'b0; req_addr = '0; flush = 1'b0;

        // Reset state.
        #12;
        check_idle_out("rst", NOP, 32'd0);
        check("rst_boot",  {31'd0, boot_done}, 32'd0);
        check("rst_ready", {31'd0, ld_ready},  32'd1);
        check("rst_stall", {31'd0, stall_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // T1 boot: four words, last flagged; requests during LOAD are ignored.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = 32'hA0 + i; ld_last = (i == 3);
            req_valid = 1'b1; req_addr = 32'h0;
            mid();
            check($sformatf("t1_stall%0d", i), {31'd0, stall_req}, 32'd1);
            check($sformatf("t1_boot%0d", i),  {31'd0, boot_done}, 32'd0);
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0; req_valid = 1'b0;
        mid();
        check("t1_boot_done", {31'd0, boot_done}, 32'd1);
        check("t1_ready_off", {31'd0, ld_ready},  32'd0);
        check("t1_stall_off", {31'd0, stall_req}, 32'd0);
        check("t1_no_rsp",    {31'd0, rsp_valid}, 32'd0);
        step();

        // T2 single read of word 2.
        read_one("t2", 32'h8, 32'hA2, 1'b0);
        mid();
        check_idle_out("t2_hold", 32'hA2, 32'h8);
        check("t2_idle_stall", {31'd0, stall_req}, 32'd0);
        step();

        // T3 back-to-back: second request issued in the first response cycle.
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        step();
        mid();
        check_rsp("t3_a", 32'hA0, 32'h0, 1'b0);
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0;
        mid();
        check("t3_gap_valid", {31'd0, rsp_valid}, 32'd0);
        check("t3_gap_instr", rsp_instr, 32'hA0);
        step();
        mid();
        check_rsp("t3_b", 32'hA1, 32'h4, 1'b0);
        step();

        // T4a flush alone while waiting: no response, idle next cycle.
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        req_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        mid();
        check("t4a_valid", {31'd0, rsp_valid}, 32'd0);
        check("t4a_stall", {31'd0, stall_req}, 32'd0);
        step();
        mid();
        check_idle_out("t4a_late", 32'hA1, 32'h4);
        step();

        // T4b flush with redirected request in the same cycle.
        req_valid = 1'b1; req_addr = 32'h4;
        step();
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
        mid();
        check("t4b_n1_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        mid();
        check("t4b_n2_valid", {31'd0, rsp_valid}, 32'd0);
        check("t4b_n2_stall", {31'd0, stall_req}, 32'd1);
        step();
        mid();
        check_rsp("t4b_n3", 32'hA3, 32'hC, 1'b0);
        step();

        // T4c flush landing on the response cycle suppresses the response.
        req_valid = 1'b1; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        mid();
        check_idle_out("t4c_rsp", 32'hA3, 32'hC);
        step();
        flush = 1'b0;
        mid();
        check("t4c_stall", {31'd0, stall_req}, 32'd0);
        check("t4c_valid", {31'd0, rsp_valid}, 32'd0);
        step();

        // T5 faults: misaligned and first out-of-range word.
        read_one("t5_mis", 32'h6, NOP, 1'b1);
        read_one("t5_oor", 32'd4096, NOP, 1'b1);
        mid();
        check("t5_fault_clr", {31'd0, addr_fault}, 32'd0);
        check("t5_hold", rsp_instr, NOP);
        step();

        // T6 reset mid-read, reload one word, older words still present.
        req_valid = 1'b1; req_addr = 32'h8;
        step();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_out("t6_rst", NOP, 32'd0);
        check("t6_boot",  {31'd0, boot_done}, 32'd0);
        check("t6_ready", {31'd0, ld_ready},  32'd1);
        check("t6_stall", {31'd0, stall_req}, 32'd1);
        step();
        mid();
        check("t6_hold_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        ld_valid = 1'b1; ld_data = 32'hB0; ld_last = 1'b1;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        mid();
        check("t6_boot_done", {31'd0, boot_done}, 32'd1);
        step();
        read_one("t6_old", 32'h4, 32'hA1, 1'b0);
        read_one("t6_new", 32'h0, 32'hB0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
